mult_iter_unit: RTL and testbench
=================================

MULT_ITER_UNIT -- requirements
Module: mult_iter_unit

Interface
REQ-001 SHALL have parameter WIDTH, default WD_SIZE: operand and result width in bits.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: multiplier bits retired per iteration; a power of two that divides WIDTH.
REQ-003 SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port valid_i, input, 1: request present.
REQ-006 SHALL have ports opcode_i, funct7_i and funct3_i, inputs, OPCODE_SIZE/FUNCT7_SIZE/FUNCT3_SIZE: instruction fields.
REQ-007 SHALL have ports op1_data_i and op2_data_i, inputs, WIDTH: rs1 and rs2 operands.
REQ-008 SHALL have port kill_i, input, 1: flush of any in-flight operation.
REQ-009 SHALL have port ready_o, output, 1: unit can accept a request.
REQ-010 SHALL have port valid_result_o, output, 1: result_o is valid.
REQ-011 SHALL have port result_o, output, WIDTH: selected product half.
REQ-012 SHALL have port result_ready_i, input, 1: consumer takes the result.

Function
REQ-013 SHALL run an FSM with states IDLE, BUSY and DONE; ready_o=1 only in IDLE; valid_result_o=1 only in DONE.
REQ-014 SHALL accept a request on an edge in IDLE with valid_i=1, opcode_i=OPCODE_OP, funct7_i=F7_MULDIV and funct3_i[2]=0; any other request SHALL be ignored, leaving the unit in IDLE.
REQ-015 SHALL latch the operands and funct3 on acceptance and move to BUSY; inputs changing after acceptance SHALL have no effect.
REQ-016 SHALL take operand magnitudes according to the operation: MUL and MULH treat both operands as signed; MULHSU treats op1 as signed and op2 as unsigned; MULHU treats both as unsigned.
REQ-017 SHALL, in each BUSY cycle, add BITS_PER_CYCLE partial products into a 2*WIDTH accumulator and decrement an iteration counter.
REQ-018 SHALL move to DONE after WIDTH/BITS_PER_CYCLE BUSY edges; with the default parameters the first cycle with valid_result_o=1 is 33 edges after acceptance.
REQ-019 SHALL apply two's-complement negation to the 2*WIDTH product when the operand signs differ, registered on the last iteration.
REQ-020 SHALL drive result_o with the low WIDTH bits of the product for MUL and the high WIDTH bits for MULH, MULHSU and MULHU.
REQ-021 SHALL hold valid_result_o and result_o stable in DONE until result_ready_i=1, then return to IDLE on that edge.
REQ-022 SHALL return a kill_i=1 edge in any state to IDLE, discarding the operation, with no valid_result_o for it; kill_i SHALL take priority over result_ready_i and acceptance.
REQ-023 SHALL not accept a new request on the same edge that DONE exits; the next acceptance is possible at the following edge at the earliest.
REQ-024 SHALL drive result_o to 0 whenever the unit is not in DONE.

Reset
REQ-025 SHALL, on any edge with reset=1, force the state to IDLE, set ready_o=1, valid_result_o=0 and result_o=0, and clear the accumulator and counter, including mid-BUSY and mid-DONE.
REQ-026 SHALL give reset priority over kill_i and all other inputs.

Configuration
REQ-027 SHALL, when MULT_EARLY_OUT_EN is defined, move from BUSY to DONE after any BUSY edge at which the remaining unshifted multiplier bits are all zero; minimum latency is 2 edges.
REQ-028 SHALL, when MULT_EARLY_OUT_EN is undefined, have a fixed latency of WIDTH/BITS_PER_CYCLE+1 edges; results SHALL be identical in both builds.

Structure
REQ-029 SHALL place F7_MULDIV, F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU and the enum mult_state_t in PARAMS_pkg.
REQ-030 SHALL use one combinational sub-module, mult_step, that forms the BITS_PER_CYCLE partial-product sum and shifted multiplier for one iteration.

Verification (WIDTH=32, BITS_PER_CYCLE=1 unless stated)
REQ-031 SHALL cover MUL 7*6 -> result_o=42 at edge 33; ready_o=0 from edge 1 until exit from DONE.
REQ-032 SHALL cover MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MUL 0xFFFFFFFF*3 -> 0xFFFFFFFD.
REQ-033 SHALL cover result_ready_i=0 for 5 cycles in DONE, with a new valid_i meanwhile -> result held stable and the new request ignored; IDLE one edge after result_ready_i=1.
REQ-034 SHALL cover kill_i at BUSY cycle 10 -> IDLE next edge, ready_o=1 and no valid_result_o; a following MUL 2*3 -> 6.
REQ-035 SHALL cover reset=1 mid-BUSY -> all outputs at reset values next edge; also ADD (funct7_i=F7_ADD) with valid_i -> ignored.
REQ-036 SHALL cover MUL 5*1 with MULT_EARLY_OUT_EN -> 5 at edge 2, and without it -> 5 at edge 33; BITS_PER_CYCLE=4 with MUL 0x1234*0x5678 -> 0x06260060 at edge 9.

Source files
------------

// File: rtl/mult_iter_unit_pkg.sv
// Shared constants and FSM state type for the iterative multiplier.
// Instruction field encodings follow the RV32M OP/MULDIV space.
package PARAMS_pkg;

    localparam int WD_SIZE     = 32;
    localparam int OPCODE_SIZE = 7;
    localparam int FUNCT7_SIZE = 7;
    localparam int FUNCT3_SIZE = 3;

    localparam logic [OPCODE_SIZE-1:0] OPCODE_OP  = 7'b0110011;
    localparam logic [FUNCT7_SIZE-1:0] F7_MULDIV  = 7'b0000001;
    localparam logic [FUNCT7_SIZE-1:0] F7_ADD     = 7'b0000000;

    localparam logic [FUNCT3_SIZE-1:0] F3_MUL    = 3'b000;
    localparam logic [FUNCT3_SIZE-1:0] F3_MULH   = 3'b001;
    localparam logic [FUNCT3_SIZE-1:0] F3_MULHSU = 3'b010;
    localparam logic [FUNCT3_SIZE-1:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_iter_unit_step.sv
// One shift-add iteration: sums BITS_PER_CYCLE partial products and
// advances the multiplicand/multiplier for the next iteration.
module mult_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] sum_o,
    output logic [2*WIDTH-1:0] mcand_next_o,
    output logic [WIDTH-1:0]   mplier_next_o
);

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_i[i]) begin
                sum_o = sum_o + (mcand_i << i);
            end
        end
    end

    assign mcand_next_o  = mcand_i << BITS_PER_CYCLE;
    assign mplier_next_o = mplier_i >> BITS_PER_CYCLE;

endmodule

// File: rtl/mult_iter_unit.sv
// Iterative sign-magnitude multiplier for MUL/MULH/MULHSU/MULHU.
// Optional feature macro: MULT_EARLY_OUT_EN (finish once the multiplier is exhausted).
module mult_iter_unit
    import PARAMS_pkg::*;
#(
    parameter int WIDTH          = WD_SIZE,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic [OPCODE_SIZE-1:0] opcode_i,
    input  logic [FUNCT7_SIZE-1:0] funct7_i,
    input  logic [FUNCT3_SIZE-1:0] funct3_i,
    input  logic [WIDTH-1:0]       op1_data_i,
    input  logic [WIDTH-1:0]       op2_data_i,
    input  logic                   kill_i,
    output logic                   ready_o,
    output logic                   valid_result_o,
    output logic [WIDTH-1:0]       result_o,
    input  logic                   result_ready_i,
    output mult_state_t            dbg_state_o
);

    localparam int ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);

    mult_state_t              r_state;
    mult_state_t              w_state_next;
    logic [2*WIDTH-1:0]       r_acc;
    logic [2*WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]         r_mplier;
    logic [CW-1:0]            r_cnt;
    logic                     r_neg;
    logic [FUNCT3_SIZE-1:0]   r_funct3;

    logic                     w_accept;
    logic                     w_op1_neg;
    logic                     w_op2_neg;
    logic [WIDTH-1:0]         w_op1_mag;
    logic [WIDTH-1:0]         w_op2_mag;
    logic [2*WIDTH-1:0]       w_sum;
    logic [2*WIDTH-1:0]       w_acc_sum;
    logic [2*WIDTH-1:0]       w_mcand_next;
    logic [WIDTH-1:0]         w_mplier_next;
    logic                     w_last;

    assign w_accept = valid_i && (opcode_i == OPCODE_OP) && (funct7_i == F7_MULDIV)
                      && !funct3_i[2];

    // MULHU is the only unsigned op1; only MUL/MULH treat op2 as signed.
    assign w_op1_neg = (funct3_i != F3_MULHU) && op1_data_i[WIDTH-1];
    assign w_op2_neg = ((funct3_i == F3_MUL) || (funct3_i == F3_MULH)) && op2_data_i[WIDTH-1];
    assign w_op1_mag = w_op1_neg ? (~op1_data_i + 1'b1) : op1_data_i;
    assign w_op2_mag = w_op2_neg ? (~op2_data_i + 1'b1) : op2_data_i;

    mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .mcand_i       (r_mcand),
        .mplier_i      (r_mplier),
        .sum_o         (w_sum),
        .mcand_next_o  (w_mcand_next),
        .mplier_next_o (w_mplier_next)
    );

    assign w_acc_sum = r_acc + w_sum;

`ifdef MULT_EARLY_OUT_EN
    assign w_last = (r_cnt == CW'(1)) || (w_mplier_next == '0);
`else
    assign w_last = (r_cnt == CW'(1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Kill overrides completion handshake and acceptance alike.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)       w_state_next = BUSY;
            BUSY:    if (w_last)         w_state_next = DONE;
            DONE:    if (result_ready_i) w_state_next = IDLE;
            default:                     w_state_next = IDLE;
        endcase
        if (kill_i) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || kill_i) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_funct3 <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, w_op1_mag};
                        r_mplier <= w_op2_mag;
                        r_cnt    <= CW'(ITERS);
                        r_neg    <= w_op1_neg ^ w_op2_neg;
                        r_funct3 <= funct3_i;
                    end
                end
                BUSY: begin
                    r_mcand  <= w_mcand_next;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt - CW'(1);
                    if (w_last && r_neg) begin
                        r_acc <= ~w_acc_sum + 1'b1;
                    end else begin
                        r_acc <= w_acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o        = (r_state == IDLE);
    assign valid_result_o = (r_state == DONE);
    assign result_o       = (r_state != DONE)     ? '0 :
                            (r_funct3 == F3_MUL)  ? r_acc[WIDTH-1:0] :
                                                    r_acc[2*WIDTH-1:WIDTH];
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_mult_iter_unit.sv
// Self-checking bench for mult_iter_unit: default instance (BITS_PER_CYCLE=1)
// plus a BITS_PER_CYCLE=4 instance, with a queue-based scoreboard.
module tb_mult_iter_unit;
    import PARAMS_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic                   valid_i;
    logic [OPCODE_SIZE-1:0] opcode_i;
    logic [FUNCT7_SIZE-1:0] funct7_i;
    logic [FUNCT3_SIZE-1:0] funct3_i;
    logic [31:0]            op1_data_i;
    logic [31:0]            op2_data_i;
    logic                   kill_i;
    logic                   ready_o;
    logic                   valid_result_o;
    logic [31:0]            result_o;
    logic                   result_ready_i;
    mult_state_t            dbg_state_o;

    logic                   valid4_i;
    logic [FUNCT3_SIZE-1:0] funct3_4_i;
    logic [31:0]            op1_4_i;
    logic [31:0]            op2_4_i;
    logic                   ready4_o;
    logic                   valid_result4_o;
    logic [31:0]            result4_o;
    logic                   result_ready4_i;
    mult_state_t            dbg_state4_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mult_iter_unit u_dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .opcode_i       (opcode_i),
        .funct7_i       (funct7_i),
        .funct3_i       (funct3_i),
        .op1_data_i     (op1_data_i),
        .op2_data_i     (op2_data_i),
        .kill_i         (kill_i),
        .ready_o        (ready_o),
        .valid_result_o (valid_result_o),
        .result_o       (result_o),
        .result_ready_i (result_ready_i),
        .dbg_state_o    (dbg_state_o)
    );

    mult_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid4_i),
        .opcode_i       (OPCODE_OP),
        .funct7_i       (F7_MULDIV),
        .funct3_i       (funct3_4_i),
        .op1_data_i     (op1_4_i),
        .op2_data_i     (op2_4_i),
        .kill_i         (1'b0),
        .ready_o        (ready4_o),
        .valid_result_o (valid_result4_o),
        .result_o       (result4_o),
        .result_ready_i (result_ready4_i),
        .dbg_state_o    (dbg_state4_o)
    );

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [64:0]  ea;
        logic signed [64:0]  eb;
        logic signed [129:0] full;
        ea   = (f3 == F3_MULHU) ? $signed({1'b0, a}) : $signed({a[31], a});
        eb   = (f3 == F3_MUL || f3 == F3_MULH) ? $signed({b[31], b}) : $signed({1'b0, b});
        full = ea * eb;
        return (f3 == F3_MUL) ? full[31:0] : full[63:32];
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] b);
`ifdef MULT_EARLY_OUT_EN
        logic [31:0] m;
        int bl;
        m  = ((f3 == F3_MUL || f3 == F3_MULH) && b[31]) ? (~b + 32'd1) : b;
        bl = 0;
        for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
        if (bl == 0) bl = 1;
        return bl + 1;
`else
        return 33;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [6:0] f7, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b);
        valid_i    = 1'b1;
        opcode_i   = OPCODE_OP;
        funct7_i   = f7;
        funct3_i   = f3;
        op1_data_i = a;
        op2_data_i = b;
    endtask

    // Issue one op, wait for DONE, compare latency and result, then drain.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_v);
        int n;
        int lat;
        logic busy_ok;
        logic [31:0] e;
        exp_q.push_back(exp_v);
        lat = exp_latency(f3, b);
        drive_req(F7_MULDIV, f3, a, b);
        tick();
        valid_i    = 1'b0;
        op1_data_i = $urandom;
        op2_data_i = $urandom;
        funct3_i   = 3'($urandom_range(0, 3));
        n = 1;
        busy_ok = 1'b1;
        while (!valid_result_o && n < 200) begin
            if (ready_o !== 1'b0) busy_ok = 1'b0;
            tick();
            n++;
        end
        checks++;
        if (valid_result_o !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: valid_result_o=%b after %0d edges, required 1", name,
                     valid_result_o, n);
            void'(exp_q.pop_front());
            return;
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_busy: ready_o seen high while busy, required 0", name);
        end
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, n, lat);
        end
        e = exp_q.pop_front();
        checks++;
        if (result_o !== e) begin
            errors++;
            $display("FAIL %s result: got %h, required %h", name, result_o, e);
        end
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_result_o !== 1'b0 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL %s drain: ready=%b valid=%b result=%h, required 1 0 0", name,
                     ready_o, valid_result_o, result_o);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (ready_o !== 1'b1 || valid_result_o !== 1'b0 || result_o !== 32'h0 ||
            dbg_state_o !== IDLE) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b result=%h state=%0d, required 1 0 0 0",
                     ready_o, valid_result_o, result_o, dbg_state_o);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mul_basic;
        run_op("mul_7x6", F3_MUL, 32'd7, 32'd6, 32'd42);
        run_op("mulh_min", F3_MULH, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulhu_max", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mulhsu_max", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mul_neg1x3", F3_MUL, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD);
        run_op("mul_zero", F3_MUL, 32'h12345678, 32'd0, 32'd0);
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 6; i++) begin
            f3 = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            run_op("rand", f3, a, b, model(f3, a, b));
        end
    endtask

    task automatic test_stall;
        int n;
        logic [31:0] e;
        exp_q.push_back(32'd56088);
        drive_req(F7_MULDIV, F3_MUL, 32'd123, 32'd456);
        tick();
        valid_i = 1'b0;
        n = 1;
        while (!valid_result_o && n < 200) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        drive_req(F7_MULDIV, F3_MUL, 32'd9, 32'd9);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid_result_o !== 1'b1 || result_o !== e) begin
                errors++;
                $display("FAIL stall_hold: valid=%b result=%h, required 1 %h",
                         valid_result_o, result_o, e);
            end
            tick();
        end
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        checks++;
        if (dbg_state_o !== IDLE || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_exit: state=%0d ready=%b, required IDLE 1", dbg_state_o, ready_o);
        end
        valid_i = 1'b0;
        tick();
        checks++;
        if (dbg_state_o !== IDLE) begin
            errors++;
            $display("FAIL stall_no_accept: state=%0d, required IDLE", dbg_state_o);
        end
    endtask

    task automatic test_kill;
        logic seen;
        exp_q.push_back(32'd20000);
        drive_req(F7_MULDIV, F3_MUL, 32'd100, 32'd200);
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        kill_i         = 1'b1;
        result_ready_i = 1'b1;
        tick();
        kill_i         = 1'b0;
        result_ready_i = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (ready_o !== 1'b1 || valid_result_o !== 1'b0 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL kill_idle: ready=%b valid=%b result=%h, required 1 0 0",
                     ready_o, valid_result_o, result_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (valid_result_o !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL kill_no_result: valid_result_o seen %b, required 0", seen);
        end
        run_op("mul_2x3_after_kill", F3_MUL, 32'd2, 32'd3, 32'd6);
    endtask

    task automatic test_reset_mid;
        drive_req(F7_MULDIV, F3_MULH, 32'hDEADBEEF, 32'h0BADF00D);
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        kill_i = 1'b1;
        tick();
        reset = 1'b0;
        kill_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_result_o !== 1'b0 || result_o !== 32'h0 ||
            dbg_state_o !== IDLE) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b result=%h state=%0d, required 1 0 0 0",
                     ready_o, valid_result_o, result_o, dbg_state_o);
        end
        drive_req(F7_ADD, 3'b000, 32'd5, 32'd6);
        tick();
        checks++;
        if (dbg_state_o !== IDLE || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ignore_add: state=%0d ready=%b, required IDLE 1", dbg_state_o, ready_o);
        end
        drive_req(F7_MULDIV, 3'b100, 32'd5, 32'd6);
        tick();
        checks++;
        if (dbg_state_o !== IDLE) begin
            errors++;
            $display("FAIL ignore_div: state=%0d, required IDLE", dbg_state_o);
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_early_out;
        run_op("mul_5x1", F3_MUL, 32'd5, 32'd1, 32'd5);
    endtask

    task automatic test_bpc4;
        int n;
        int lat;
        logic [31:0] e;
`ifdef MULT_EARLY_OUT_EN
        lat = 5;
`else
        lat = 9;
`endif
        exp_q.push_back(32'h06260060);
        funct3_4_i = F3_MUL;
        op1_4_i    = 32'h1234;
        op2_4_i    = 32'h5678;
        valid4_i   = 1'b1;
        tick();
        valid4_i = 1'b0;
        op1_4_i  = $urandom;
        op2_4_i  = $urandom;
        n = 1;
        while (!valid_result4_o && n < 100) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        checks++;
        if (n != lat || result4_o !== e) begin
            errors++;
            $display("FAIL bpc4_mul: got %h at edge %0d, required %h at edge %0d",
                     result4_o, n, e, lat);
        end
        result_ready4_i = 1'b1;
        tick();
        result_ready4_i = 1'b0;
        exp_q.push_back(model(F3_MULH, 32'hF0001234, 32'h7FFF8001));
        funct3_4_i = F3_MULH;
        op1_4_i    = 32'hF0001234;
        op2_4_i    = 32'h7FFF8001;
        valid4_i   = 1'b1;
        tick();
        valid4_i = 1'b0;
        n = 1;
        while (!valid_result4_o && n < 100) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        checks++;
        if (valid_result4_o !== 1'b1 || result4_o !== e) begin
            errors++;
            $display("FAIL bpc4_mulh: valid=%b result=%h, required 1 %h",
                     valid_result4_o, result4_o, e);
        end
        result_ready4_i = 1'b1;
        tick();
        result_ready4_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        valid_i         = 1'b0;
        opcode_i        = '0;
        funct7_i        = '0;
        funct3_i        = '0;
        op1_data_i      = '0;
        op2_data_i      = '0;
        kill_i          = 1'b0;
        result_ready_i  = 1'b0;
        valid4_i        = 1'b0;
        funct3_4_i      = '0;
        op1_4_i         = '0;
        op2_4_i         = '0;
        result_ready4_i = 1'b0;
        test_reset();
        test_mul_basic();
        test_random();
        test_stall();
        test_kill();
        test_reset_mid();
        test_early_out();
        test_bpc4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
